// File: rtl/arm_sequencer_pkg.sv
// Shared types and defaults for the arm sequencer.
// Holds the FSM state encoding and default settle/timeout constants.
package arm_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_FIN  = 2'd2,
      ST_FLT  = 2'd3
   } state_e;

   localparam int SETTLE_DEF = 5;
   localparam int TMO_DEF    = 50000000;

endpackage

// File: rtl/step_settle.sv
// Per-step settle and timeout counters for the arm sequencer.
// Ports: clk, rst_n, en (in MOVE), all_pos (&AT_POS) -> done, timeout.
module step_settle
   import arm_sequencer_pkg::*;
#(
   parameter int SETTLE = SETTLE_DEF,
   parameter int TMO    = TMO_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic all_pos,
   output logic done,
   output logic timeout
);

   localparam int SCW = $clog2(SETTLE + 1);
   localparam int TCW = $clog2(TMO + 1);

   logic [SCW-1:0] settle_q, settle_d;
   logic [TCW-1:0] tmo_q, tmo_d;
   logic           first_q, first_d;

   // done fires on the cycle whose good sample brings the count to SETTLE
   always_comb begin
      done    = en && !first_q && all_pos
                && (settle_q == SCW'(SETTLE - 1));
      timeout = en && !done && (tmo_q == TCW'(TMO - 1));
      settle_d = settle_q;
      tmo_d    = tmo_q;
      first_d  = first_q;
      if (!en || done) begin
         settle_d = '0;
         tmo_d    = '0;
         first_d  = 1'b1;
      end else begin
         first_d = 1'b0;
         tmo_d   = tmo_q + TCW'(1);
         // first cycle of a step ignores AT_POS
         if (first_q)
            settle_d = '0;
         else if (all_pos)
            settle_d = settle_q + SCW'(1);
         else
            settle_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_q <= '0;
         tmo_q    <= '0;
         first_q  <= 1'b1;
      end else begin
         settle_q <= settle_d;
         tmo_q    <= tmo_d;
         first_q  <= first_d;
      end
   end

endmodule

// File: rtl/arm_sequencer.sv
// Servo arm step sequencer: plays a position table, one step per settle.
// Ports: CLK, RST_N, START/ABORT/LOOP, WR_* table write, AT_POS in;
// DESIRED, STEP, BUSY, DONE, FAULT out (all registered).
module arm_sequencer
   import arm_sequencer_pkg::*;
#(
   parameter int NCH    = 3,
   parameter int NSTEP  = 4,
   parameter int PW     = 20,
   parameter int SETTLE = SETTLE_DEF,
   parameter int TMO    = TMO_DEF,
   localparam int SW    = $clog2(NSTEP),
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic              ABORT,
   input  logic              LOOP,
   input  logic              WR_EN,
   input  logic [SW-1:0]     WR_STEP,
   input  logic [CW-1:0]     WR_CH,
   input  logic [PW-1:0]     WR_DATA,
   input  logic [NCH-1:0]    AT_POS,
   output logic [NCH*PW-1:0] DESIRED,
   output logic [SW-1:0]     STEP,
   output logic              BUSY,
   output logic              DONE,
   output logic              FAULT
);

   state_e              state_q, state_d;
   logic [SW-1:0]       step_q, step_d;
   logic [NCH*PW-1:0]   desired_q, desired_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                fault_q, fault_d;
   logic [PW-1:0]       tbl_q [NSTEP][NCH];
   logic [PW-1:0]       tbl_d [NSTEP][NCH];
   logic                st_done, st_tmo;

   step_settle #(
      .SETTLE (SETTLE),
      .TMO    (TMO)
   ) u_settle (
      .clk     (CLK),
      .rst_n   (RST_N),
      .en      (state_q == ST_MOVE),
      .all_pos (&AT_POS),
      .done    (st_done),
      .timeout (st_tmo)
   );

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      desired_d = desired_q;
      tbl_d     = tbl_q;
      if (WR_EN && !busy_q && (int'(WR_CH) < NCH))
         tbl_d[WR_STEP][WR_CH] = WR_DATA;
      unique case (state_q)
         ST_IDLE, ST_FLT: begin
            if (START) begin
               state_d = ST_MOVE;
               step_d  = '0;
            end
         end
         ST_MOVE: begin
            if (st_done) begin
               if (step_q != SW'(NSTEP - 1))
                  step_d = step_q + SW'(1);
               else if (LOOP)
                  step_d = '0;
               else
                  state_d = ST_FIN;
            end else if (st_tmo) begin
               state_d = ST_FLT;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // abort overrides start and step completion
      if (ABORT) begin
         state_d = ST_IDLE;
         step_d  = step_q;
      end
      // load targets on the edge that enters each step
      if (state_d == ST_MOVE)
         for (int c = 0; c < NCH; c++)
            desired_d[c*PW +: PW] = tbl_q[step_d][c];
      busy_d  = (state_d == ST_MOVE) || (state_d == ST_FIN);
      done_d  = (state_d == ST_FIN);
      fault_d = (state_d == ST_FLT);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         step_q    <= '0;
         desired_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
         for (int s = 0; s < NSTEP; s++)
            for (int c = 0; c < NCH; c++)
               tbl_q[s][c] <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         desired_q <= desired_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fault_q   <= fault_d;
         tbl_q     <= tbl_d;
      end
   end

   assign DESIRED = desired_q;
   assign STEP    = step_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign FAULT   = fault_q;

endmodule
